chacha20_stream_finaliser: RTL and testbench



---
 rtl/chacha20_stream_finaliser.sv | 135 +++++++++++++
 tb/tb_chacha20_stream_finaliser.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_stream_finaliser.sv
// ChaCha20 stream finaliser: latches one 16-word block, forms the feed-forward
// sums (optionally XORed with a data block) and streams them out LANES words
// per beat, lowest word first, under valid/ready flow control.
module chacha20_stream_finaliser #(
    parameter int LANES = 4,
    localparam int BEATS = 16 / LANES,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [511:0]          unmixed_round_output,
    input  logic [511:0]          round_input,
    input  logic [511:0]          data_in,
    input  logic                  xor_enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data,
    output logic [BEAT_W-1:0]     out_beat,
    output logic                  out_last
);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_illegal
        $error("chacha20_stream_finaliser: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [511:0]       result_r;
    logic [511:0]       result_nxt_s;
    logic [BEAT_W-1:0]  beat_r;
    logic               in_fire_s;
    logic               out_fire_s;
    logic               last_s;

    assign in_fire_s  = in_valid && (state_r == ST_IDLE);
    assign out_fire_s = out_ready && (state_r == ST_EMIT);
    assign last_s     = (beat_r == BEAT_W'(BEATS - 1));

    // Per-word modular feed-forward add; carries never cross word boundaries
    always_comb begin
        result_nxt_s = 512'd0;
        for (int j = 0; j < 16; j++) begin
            result_nxt_s[32*j +: 32] = (round_input[32*j +: 32] + unmixed_round_output[32*j +: 32])
                                     ^ (data_in[32*j +: 32] & {32{xor_enable}});
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: accept in IDLE, return to IDLE once the last beat is taken
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_fire_s) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_fire_s && last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Block result register, loaded only at the input handshake
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            result_r <= 512'd0;
        end else if (in_fire_s) begin
            result_r <= result_nxt_s;
        end else begin
            result_r <= result_r;
        end
    end

    // Beat counter: cleared on accept, advanced on every non-final output handshake
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            beat_r <= {BEAT_W{1'b0}};
        end else if (in_fire_s) begin
            beat_r <= {BEAT_W{1'b0}};
        end else if (out_fire_s && !last_s) begin
            beat_r <= beat_r + BEAT_W'(1);
        end else begin
            beat_r <= beat_r;
        end
    end

    // FSM outputs and beat slice select, all derived from registered state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_beat  = beat_r;
        out_data  = {(32*LANES){1'b0}};
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_last  = last_s;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        for (int b = 0; b < BEATS; b++) begin
            out_data = out_data | ((beat_r == BEAT_W'(b)) ? result_r[b*32*LANES +: 32*LANES]
                                                          : {(32*LANES){1'b0}});
        end
    end

endmodule

// File: tb/tb_chacha20_stream_finaliser.sv
// Self-checking bench for chacha20_stream_finaliser (LANES = 4, 1, 16).
module tb_chacha20_stream_finaliser;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic         clear_n;
    logic [511:0] um_v, ri_v, dt_v;
    logic         xe;

    logic         in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
    logic [127:0] out_data4;
    logic [1:0]   out_beat4;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
    logic [31:0]  out_data1;
    logic [3:0]   out_beat1;
    logic         in_valid16, in_ready16, out_valid16, out_ready16, out_last16;
    logic [511:0] out_data16;
    logic [0:0]   out_beat16;

    chacha20_stream_finaliser #(.LANES(4)) dut4 (
        .clock(clock), .clear_n(clear_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .unmixed_round_output(um_v), .round_input(ri_v), .data_in(dt_v), .xor_enable(xe),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_beat(out_beat4), .out_last(out_last4));

    chacha20_stream_finaliser #(.LANES(1)) dut1 (
        .clock(clock), .clear_n(clear_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .unmixed_round_output(um_v), .round_input(ri_v), .data_in(dt_v), .xor_enable(xe),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_beat(out_beat1), .out_last(out_last1));

    chacha20_stream_finaliser #(.LANES(16)) dut16 (
        .clock(clock), .clear_n(clear_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .unmixed_round_output(um_v), .round_input(ri_v), .data_in(dt_v), .xor_enable(xe),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
        .out_beat(out_beat16), .out_last(out_last16));

    localparam logic [31:0] RFC_IN [16] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    localparam logic [31:0] RFC_RND [16] = '{
        32'h837778ab, 32'he238d763, 32'ha67ae21e, 32'h5950bb2f,
        32'hc4f2d0c7, 32'hfc62bb2f, 32'h8fa018fc, 32'h3f5ec7b7,
        32'h335271c2, 32'hf29489f3, 32'heabda8fc, 32'h82e46ebd,
        32'hd19c12b4, 32'hb04e16de, 32'h9e83d0cb, 32'h4e3c50a2};
    localparam logic [31:0] RFC_OUT [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    // Reference model: the block as sixteen independent words
    logic [31:0] ri_w [16];
    logic [31:0] um_w [16];
    logic [31:0] dt_w [16];
    logic        xe_m;
    logic [31:0] exp_blk [16];

    function automatic void apply_inputs();
        for (int j = 0; j < 16; j++) begin
            ri_v[32*j +: 32] = ri_w[j];
            um_v[32*j +: 32] = um_w[j];
            dt_v[32*j +: 32] = dt_w[j];
        end
        xe = xe_m;
    endfunction

    function automatic void latch_expected();
        logic [31:0] s;
        for (int j = 0; j < 16; j++) begin
            s = ri_w[j] + um_w[j];
            exp_blk[j] = xe_m ? (s ^ dt_w[j]) : s;
        end
    endfunction

    function automatic void rand_block();
        for (int j = 0; j < 16; j++) begin
            ri_w[j] = $urandom;
            um_w[j] = $urandom;
            dt_w[j] = $urandom;
        end
        xe_m = 1'($urandom_range(0, 1));
    endfunction

    function automatic void rfc_block();
        for (int j = 0; j < 16; j++) begin
            ri_w[j] = RFC_IN[j];
            um_w[j] = RFC_RND[j];
            dt_w[j] = $urandom;
        end
        xe_m = 1'b0;
    endfunction

    // Offer a block to dut4 and wait (bounded) for it to be accepted
    task automatic send4();
        int n = 0;
        apply_inputs();
        in_valid4 = 1'b1;
        while (in_ready4 !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL accept4 in_ready never rose within %0d cycles", n);
        end
        latch_expected();
        @(negedge clock);
        in_valid4 = 1'b0;
    endtask

    // Drain one block from dut4; mode 0 = always ready, 1 = 1,0,0 pattern, 2 = random
    task automatic collect4(input int mode, input string tag);
        int          beat = 0;
        int          cyc = 0;
        bit          prev_stall = 1'b0;
        logic [127:0] prev_d = 128'd0;
        logic [1:0]  prev_b = 2'd0;
        logic [127:0] ed;
        logic [1:0]  eb;
        logic        r;
        while (beat < 4 && cyc < 200) begin
            eb = beat[1:0];
            for (int k = 0; k < 4; k++) ed[32*k +: 32] = exp_blk[beat*4 + k];
            checks++;
            if (out_valid4 !== 1'b1) begin
                errors++;
                $display("FAIL %s out_valid got %b want 1 (beat %0d)", tag, out_valid4, beat);
            end
            checks++;
            if (in_ready4 !== 1'b0) begin
                errors++;
                $display("FAIL %s in_ready_emit got %b want 0 (beat %0d)", tag, in_ready4, beat);
            end
            checks++;
            if (out_beat4 !== eb) begin
                errors++;
                $display("FAIL %s out_beat got %0d want %0d", tag, out_beat4, eb);
            end
            checks++;
            if (out_last4 !== (beat == 3)) begin
                errors++;
                $display("FAIL %s out_last got %b want %b (beat %0d)", tag, out_last4, beat == 3, beat);
            end
            checks++;
            if (out_data4 !== ed) begin
                errors++;
                $display("FAIL %s out_data beat %0d got %h want %h", tag, beat, out_data4, ed);
            end
            if (prev_stall) begin
                checks++;
                if (out_data4 !== prev_d || out_beat4 !== prev_b) begin
                    errors++;
                    $display("FAIL %s stall_hold got %h/%0d want %h/%0d", tag, out_data4, out_beat4, prev_d, prev_b);
                end
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 3) == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready4 = r;
            prev_stall = !r;
            prev_d = out_data4;
            prev_b = out_beat4;
            if (r) beat++;
            cyc++;
            @(negedge clock);
        end
        out_ready4 = 1'b0;
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL %s drain timeout after %0d cycles, beats %0d", tag, cyc, beat);
        end
        if (mode == 0) begin
            checks++;
            if (cyc != 4) begin
                errors++;
                $display("FAIL %s throughput got %0d cycles want 4", tag, cyc);
            end
        end
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL %s after_last valid/ready got %b/%b want 0/1", tag, out_valid4, in_ready4);
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_last4 !== 1'b0) begin
            errors++;
            $display("FAIL reset ctrl got rdy %b vld %b last %b want 1 0 0", in_ready4, out_valid4, out_last4);
        end
        checks++;
        if (out_beat4 !== 2'd0 || out_data4 !== 128'd0) begin
            errors++;
            $display("FAIL reset data got beat %0d data %h want 0 0", out_beat4, out_data4);
        end
        checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_other got %b%b%b%b want 1010", in_ready1, out_valid1, in_ready16, out_valid16);
        end
        clear_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_rfc();
        logic [127:0] ed;
        rfc_block();
        send4();
        out_ready4 = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) ed[32*k +: 32] = RFC_OUT[b*4 + k];
            checks++;
            if (out_valid4 !== 1'b1 || out_beat4 !== b[1:0] || out_last4 !== (b == 3)) begin
                errors++;
                $display("FAIL rfc ctrl beat %0d got vld %b beat %0d last %b", b, out_valid4, out_beat4, out_last4);
            end
            checks++;
            if (out_data4 !== ed) begin
                errors++;
                $display("FAIL rfc data beat %0d got %h want %h", b, out_data4, ed);
            end
            @(negedge clock);
        end
        out_ready4 = 1'b0;
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL rfc after_last got vld %b rdy %b want 0 1", out_valid4, in_ready4);
        end
    endtask

    task automatic test_wrap_xor();
        for (int j = 0; j < 16; j++) begin
            ri_w[j] = 32'hffffffff;
            um_w[j] = 32'h00000001;
            dt_w[j] = 32'hffffffff;
        end
        xe_m = 1'b0;
        send4();
        for (int j = 0; j < 16; j++) exp_blk[j] = 32'h00000000;
        collect4(0, "wrap");
        @(negedge clock);
        xe_m = 1'b1;
        send4();
        for (int j = 0; j < 16; j++) exp_blk[j] = 32'hffffffff;
        collect4(0, "xor_ones");
        @(negedge clock);
        for (int j = 0; j < 16; j++) dt_w[j] = j;
        send4();
        for (int j = 0; j < 16; j++) exp_blk[j] = j;
        collect4(0, "xor_index");
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        rand_block();
        send4();
        // present a second block while the first is still streaming
        rand_block();
        apply_inputs();
        in_valid4 = 1'b1;
        collect4(1, "stall_a");
        send4();
        collect4(1, "stall_b");
        @(negedge clock);
    endtask

    task automatic test_reset_mid_block();
        rand_block();
        send4();
        out_ready4 = 1'b1;
        @(negedge clock);
        checks++;
        if (out_beat4 !== 2'd1) begin
            errors++;
            $display("FAIL midrst pre beat got %0d want 1", out_beat4);
        end
        @(negedge clock);
        clear_n = 1'b0;
        out_ready4 = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out_beat4 !== 2'd0 || out_data4 !== 128'd0) begin
            errors++;
            $display("FAIL midrst state got vld %b rdy %b beat %0d data %h", out_valid4, in_ready4, out_beat4, out_data4);
        end
        @(negedge clock);
        checks++;
        if (out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL midrst no_more_beats got vld %b want 0", out_valid4);
        end
        rand_block();
        send4();
        collect4(0, "midrst_next");
        @(negedge clock);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            rand_block();
            send4();
            collect4(2, "random");
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end
        @(negedge clock);
    endtask

    task automatic test_lanes1();
        rfc_block();
        apply_inputs();
        in_valid1 = 1'b1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL l1 in_ready got %b want 1", in_ready1);
        end
        @(negedge clock);
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (out_valid1 !== 1'b1 || out_beat1 !== b[3:0] || out_last1 !== (b == 15)) begin
                errors++;
                $display("FAIL l1 ctrl beat %0d got vld %b beat %0d last %b", b, out_valid1, out_beat1, out_last1);
            end
            checks++;
            if (out_data1 !== RFC_OUT[b]) begin
                errors++;
                $display("FAIL l1 data beat %0d got %h want %h", b, out_data1, RFC_OUT[b]);
            end
            @(negedge clock);
        end
        out_ready1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL l1 after_last got vld %b rdy %b want 0 1", out_valid1, in_ready1);
        end
    endtask

    task automatic test_lanes16();
        logic [511:0] ed;
        rfc_block();
        apply_inputs();
        for (int j = 0; j < 16; j++) ed[32*j +: 32] = RFC_OUT[j];
        in_valid16 = 1'b1;
        @(negedge clock);
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        checks++;
        if (out_valid16 !== 1'b1 || out_last16 !== 1'b1 || out_beat16 !== 1'b0) begin
            errors++;
            $display("FAIL l16 ctrl got vld %b last %b beat %0d want 1 1 0", out_valid16, out_last16, out_beat16);
        end
        checks++;
        if (out_data16 !== ed) begin
            errors++;
            $display("FAIL l16 data got %h want %h", out_data16, ed);
        end
        @(negedge clock);
        out_ready16 = 1'b0;
        checks++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL l16 after_last got vld %b rdy %b want 0 1", out_valid16, in_ready16);
        end
    endtask

    initial begin
        clear_n = 1'b0;
        um_v = 512'd0;
        ri_v = 512'd0;
        dt_v = 512'd0;
        xe = 1'b0;
        in_valid4 = 1'b0;
        out_ready4 = 1'b0;
        in_valid1 = 1'b0;
        out_ready1 = 1'b0;
        in_valid16 = 1'b0;
        out_ready16 = 1'b0;
        @(negedge clock);
        test_reset();
        test_rfc();
        @(negedge clock);
        test_wrap_xor();
        test_backpressure();
        test_reset_mid_block();
        test_random();
        test_lanes1();
        test_lanes16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
